fetch_queue: RTL

Decoupling FIFO between instruction fetch and decode. Captures {pc, instruction} pairs from the fetch stage and presents them in order to decode under a valid/ready handshake. Fetch advances its PC only when the queue accepts an entry, so `in_ready` drives the fetch stage's PC `load_en`. A single-cycle `flush` discards all buffered instructions on a redirect (branch, JMP, TRAP, RTI).

---
 rtl/fetch_queue_if.sv | 29 ++
 rtl/fetch_queue.sv | 67 ++++++
 2 files changed

// File: rtl/fetch_queue_if.sv
// Handshake bundle between fetch, the fetch queue and decode.
// The slave modport is the queue side; the master modport is the fetch/decode side.
interface fetch_queue_if #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
);
   localparam int LW = $clog2(DEPTH) + 1;

   logic             flush;
   logic             in_valid;
   logic [WIDTH-1:0] in_pc;
   logic [WIDTH-1:0] in_instr;
   logic             in_ready;
   logic             out_valid;
   logic [WIDTH-1:0] out_pc;
   logic [WIDTH-1:0] out_instr;
   logic             out_ready;
   logic [LW-1:0]    level;

   modport slave (
      input  flush, in_valid, in_pc, in_instr, out_ready,
      output in_ready, out_valid, out_pc, out_instr, level
   );

   modport master (
      output flush, in_valid, in_pc, in_instr, out_ready,
      input  in_ready, out_valid, out_pc, out_instr, level
   );
endinterface

// File: rtl/fetch_queue.sv
// In-order {pc, instr} FIFO decoupling fetch from decode.
// Status outputs come from registered state only; no bypass and no pass-through when full.
module fetch_queue #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 32
) (
   input  logic clk,
   input  logic reset,
   fetch_queue_if.slave q
);
   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   typedef struct packed {
      logic [WIDTH-1:0] pc;
      logic [WIDTH-1:0] instr;
   } entry_t;

   entry_t        mem_q [DEPTH];
   entry_t        mem_d [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [LW-1:0] level_q, level_d;
   logic          push, pop;

   assign q.out_valid = (level_q != '0);
   assign q.in_ready  = (level_q != LW'(DEPTH));
   assign q.out_pc    = mem_q[rd_ptr_q].pc;
   assign q.out_instr = mem_q[rd_ptr_q].instr;
   assign q.level     = level_q;

   always_comb begin
      push     = q.in_valid && q.in_ready && !q.flush;
      pop      = q.out_valid && q.out_ready && !q.flush;
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q + LW'(push) - LW'(pop);
      if (push) begin
         mem_d[wr_ptr_q] = '{pc: q.in_pc, instr: q.in_instr};
         wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (pop)
         rd_ptr_d = rd_ptr_q + AW'(1);
      // Redirect drops everything, including a push or pop in the same cycle.
      if (q.flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         level_d  = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++)
            mem_q[i] <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end
endmodule
